// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
//   pcs_state_e       : sequencer FSM state (RUN, DS_WAIT)
//   INSN_BYTES        : sequential PC increment
//   DELAY_SLOT_OFFSET : distance from a branch to its delay slot
//   LINK_OFFSET       : return address offset for JAL/JALR
package cpu_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    DS_WAIT = 1'b1
  } pcs_state_e;

  localparam int unsigned INSN_BYTES        = 4;
  localparam int unsigned DELAY_SLOT_OFFSET = 4;
  localparam int unsigned LINK_OFFSET       = 8;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a top pointer and saturating count.
// A push when full overwrites the oldest entry; a pop when empty does nothing.
// Push and pop together replace the top entry.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (pointer/count only)
//   push_i        : push data_i
//   pop_i         : pop top entry
//   data_i        : address to push
//   top_o         : top entry, 0 when empty
//   empty_o       : no valid entry
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              has_entry, do_push, do_pop, do_replace;

  assign has_entry  = (cnt_q != '0);
  // Replace only makes sense with a live top; on an empty stack it degrades to a push.
  assign do_replace = push_i & pop_i & has_entry;
  assign do_push    = push_i & ~do_replace;
  assign do_pop     = pop_i & ~push_i & has_entry;
  assign ptr_inc    = ptr_q + PTR_W'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (do_push) begin
      ptr_d = ptr_inc;
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push)         mem_q[ptr_inc] <= data_i;
    else if (do_replace) mem_q[ptr_q]   <= data_i;
  end

  assign top_o   = has_entry ? mem_q[ptr_q] : '0;
  assign empty_o = ~has_entry;

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch PC generator with MIPS delay-slot redirect handling,
// exception redirect and a return-address stack for JR $ra prediction.
// Ports:
//   w_clk, w_rst_n            : clock, async active-low reset
//   w_stall                   : hold the PC
//   w_branch_op, w_success    : taken conditional branch in EX
//   w_jump_op, w_imm_op       : jump in EX, immediate (J/JAL) or register form
//   w_link_op, w_ret_op       : push / pop the RAS
//   w_exc_req                 : redirect to EXC_VECTOR
//   w_br_pc_in                : PC of the EX branch/jump
//   w_alu_imm, w_br_imm_26    : branch offset, J-type target field
//   w_reg_pc                  : register jump target
//   w_pc_out, w_redirect      : fetch PC, non-sequential-load flag
//   w_ras_top, w_ras_empty    : predicted return address, RAS empty
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0080),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_stall,
  input  logic              w_branch_op,
  input  logic              w_success,
  input  logic              w_jump_op,
  input  logic              w_imm_op,
  input  logic              w_link_op,
  input  logic              w_ret_op,
  input  logic              w_exc_req,
  input  logic [ADDR_W-1:0] w_br_pc_in,
  input  logic [ADDR_W-1:0] w_alu_imm,
  input  logic [25:0]       w_br_imm_26,
  input  logic [ADDR_W-1:0] w_reg_pc,
  output logic [ADDR_W-1:0] w_pc_out,
  output logic              w_redirect,
  output logic [ADDR_W-1:0] w_ras_top,
  output logic              w_ras_empty
);

  pcs_state_e        state_q;
  logic [ADDR_W-1:0] pc_q, pend_q;
  logic              redir_q;

  logic                     resolve, ds_unfetched, ras_en;
  logic [ADDR_W-1:0]        pc4, seq_pc, j_tgt, r_tgt, target;
  logic signed [ADDR_W-1:0] br_off, br_tgt;

  assign resolve      = (w_branch_op & w_success) | w_jump_op;
  assign pc4          = w_br_pc_in + ADDR_W'(DELAY_SLOT_OFFSET);
  assign seq_pc       = pc_q + ADDR_W'(INSN_BYTES);
  // Fetch has not yet issued the delay slot if it is the current PC.
  assign ds_unfetched = (pc_q == pc4);

  // Offset arrives sign-extended; the sum wraps modulo 2^ADDR_W.
  assign br_off = $signed(w_alu_imm);
  assign br_tgt = $signed(pc4) + br_off;

  always_comb begin
    j_tgt       = pc4;
    j_tgt[27:0] = {w_br_imm_26, 2'b00};
    r_tgt       = {w_reg_pc[ADDR_W-1:2], 2'b00};
    if (w_jump_op) target = w_imm_op ? j_tgt : r_tgt;
    else           target = $unsigned(br_tgt);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pc_q    <= RESET_VECTOR;
      state_q <= RUN;
      pend_q  <= '0;
      redir_q <= 1'b0;
    end else begin
      redir_q <= 1'b0;
      if (w_exc_req) begin
        pc_q    <= EXC_VECTOR;
        redir_q <= 1'b1;
        state_q <= RUN;
        pend_q  <= '0;
      end else begin
        case (state_q)
          RUN: begin
            if (resolve && (ds_unfetched || w_stall)) begin
              // Park the target until the delay slot has been fetched
              // (or until a stall covering an already-fetched slot lifts).
              pend_q  <= target;
              state_q <= DS_WAIT;
              if (!w_stall) pc_q <= seq_pc;
            end else if (resolve) begin
              pc_q    <= target;
              redir_q <= 1'b1;
            end else if (!w_stall) begin
              pc_q <= seq_pc;
            end
          end
          DS_WAIT: begin
            // New resolves are dropped here: branches in delay slots are undefined.
            if (!w_stall) begin
              pc_q    <= pend_q;
              redir_q <= 1'b1;
              state_q <= RUN;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  // Only resolves actually acted upon touch the RAS.
  assign ras_en = resolve & ~w_exc_req & (state_q == RUN);

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (w_clk),
    .rst_ni  (w_rst_n),
    .push_i  (ras_en & w_jump_op & w_link_op),
    .pop_i   (ras_en & w_jump_op & w_ret_op),
    .data_i  (w_br_pc_in + ADDR_W'(LINK_OFFSET)),
    .top_o   (w_ras_top),
    .empty_o (w_ras_empty)
  );

  assign w_pc_out   = pc_q;
  assign w_redirect = redir_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        w_clk = 1'b0;
  logic        w_rst_n, w_stall, w_branch_op, w_success, w_jump_op, w_imm_op;
  logic        w_link_op, w_ret_op, w_exc_req;
  logic [31:0] w_br_pc_in, w_alu_imm, w_reg_pc;
  logic [25:0] w_br_imm_26;
  logic [31:0] w_pc_out, w_ras_top;
  logic        w_redirect, w_ras_empty;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_stall     (w_stall),
    .w_branch_op (w_branch_op),
    .w_success   (w_success),
    .w_jump_op   (w_jump_op),
    .w_imm_op    (w_imm_op),
    .w_link_op   (w_link_op),
    .w_ret_op    (w_ret_op),
    .w_exc_req   (w_exc_req),
    .w_br_pc_in  (w_br_pc_in),
    .w_alu_imm   (w_alu_imm),
    .w_br_imm_26 (w_br_imm_26),
    .w_reg_pc    (w_reg_pc),
    .w_pc_out    (w_pc_out),
    .w_redirect  (w_redirect),
    .w_ras_top   (w_ras_top),
    .w_ras_empty (w_ras_empty)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle();
    w_stall = 0; w_branch_op = 0; w_success = 0; w_jump_op = 0; w_imm_op = 0;
    w_link_op = 0; w_ret_op = 0; w_exc_req = 0;
    w_br_pc_in = 0; w_alu_imm = 0; w_br_imm_26 = 0; w_reg_pc = 0;
  endtask

  task automatic jal(input logic [31:0] br_pc);
    w_jump_op = 1; w_imm_op = 1; w_link_op = 1; w_br_pc_in = br_pc; w_br_imm_26 = 26'h40;
  endtask

  task automatic jr_ra(input logic [31:0] br_pc);
    w_jump_op = 1; w_imm_op = 0; w_ret_op = 1; w_br_pc_in = br_pc; w_reg_pc = 32'h100;
  endtask

  initial begin
    idle();
    w_rst_n = 0;
    #12;
    // 1: reset state and free run
    chk("rst_pc", w_pc_out, 32'h0);
    chk("rst_redir", {31'd0, w_redirect}, 32'd0);
    chk("rst_empty", {31'd0, w_ras_empty}, 32'd1);
    chk("rst_top", w_ras_top, 32'h0);
    w_rst_n = 1;
    step(); chk("run1", w_pc_out, 32'h4);
    step(); chk("run2", w_pc_out, 32'h8);
    step(); chk("run3", w_pc_out, 32'hC);
    step(); chk("run4", w_pc_out, 32'h10);
    chk("run_redir", {31'd0, w_redirect}, 32'd0);

    // 2: stall at PC=8
    w_rst_n = 0; #3; w_rst_n = 1;
    chk("rerst_pc", w_pc_out, 32'h0);
    step(); step();
    chk("pre_stall", w_pc_out, 32'h8);
    w_stall = 1;
    step(); chk("stall1", w_pc_out, 32'h8);
    step(); chk("stall2", w_pc_out, 32'h8);
    step(); chk("stall3", w_pc_out, 32'h8);
    chk("stall_redir", {31'd0, w_redirect}, 32'd0);
    w_stall = 0;
    step(); chk("unstall", w_pc_out, 32'hC);

    // 3: taken beq with unfetched delay slot
    w_branch_op = 1; w_success = 1; w_br_pc_in = 32'h8; w_alu_imm = 32'h20;
    step(); chk("beq_ds", w_pc_out, 32'h10);
    chk("beq_ds_redir", {31'd0, w_redirect}, 32'd0);
    idle();
    step(); chk("beq_tgt", w_pc_out, 32'h2C);
    chk("beq_redir", {31'd0, w_redirect}, 32'd1);
    step(); chk("beq_after", w_pc_out, 32'h30);
    chk("beq_after_redir", {31'd0, w_redirect}, 32'd0);

    // 3b: stall during DS_WAIT
    w_branch_op = 1; w_success = 1; w_br_pc_in = 32'h2C; w_alu_imm = 32'h20;
    step(); chk("dsst_ds", w_pc_out, 32'h34);
    idle(); w_stall = 1;
    step(); chk("dsst_hold", w_pc_out, 32'h34);
    chk("dsst_hold_redir", {31'd0, w_redirect}, 32'd0);
    w_stall = 0;
    step(); chk("dsst_tgt", w_pc_out, 32'h50);
    chk("dsst_redir", {31'd0, w_redirect}, 32'd1);

    // JR with delay slot already fetched, low bits forced to 0
    w_jump_op = 1; w_br_pc_in = 32'h40; w_reg_pc = 32'h203;
    step(); chk("jr_fetched", w_pc_out, 32'h200);
    chk("jr_redir", {31'd0, w_redirect}, 32'd1);
    idle();

    // untaken branch is sequential
    w_branch_op = 1; w_success = 0; w_br_pc_in = 32'h1FC; w_alu_imm = 32'h40;
    step(); chk("untaken", w_pc_out, 32'h204);
    chk("untaken_redir", {31'd0, w_redirect}, 32'd0);
    idle();

    // negative offset
    w_branch_op = 1; w_success = 1; w_br_pc_in = 32'h200; w_alu_imm = 32'hFFFF_FFF0;
    step(); chk("neg_ds", w_pc_out, 32'h208);
    idle();
    step(); chk("neg_tgt", w_pc_out, 32'h1F4);

    // 4: JAL then JR $ra
    jal(32'h100);
    step(); chk("jal_pc", w_pc_out, 32'h100);
    chk("jal_top", w_ras_top, 32'h108);
    chk("jal_empty", {31'd0, w_ras_empty}, 32'd0);
    idle();
    w_jump_op = 1; w_ret_op = 1; w_br_pc_in = 32'hFC; w_reg_pc = 32'h108;
    step(); chk("jr_ds", w_pc_out, 32'h104);
    chk("jr_empty", {31'd0, w_ras_empty}, 32'd1);
    chk("jr_top", w_ras_top, 32'h0);
    idle();
    step(); chk("jr_tgt", w_pc_out, 32'h108);

    // J takes upper bits from br_pc+4
    w_jump_op = 1; w_imm_op = 1; w_br_pc_in = 32'h1FFF_FFFC; w_br_imm_26 = 26'h40;
    step(); chk("j_upper", w_pc_out, 32'h2000_0100);
    idle();

    // 5: overflow and underflow
    for (int i = 1; i <= 5; i++) begin
      jal(32'(i) * 32'h100);
      step();
      idle();
    end
    chk("ovf_top", w_ras_top, 32'h508);
    jr_ra(32'h800); step(); idle();
    chk("pop1", w_ras_top, 32'h408);
    jr_ra(32'h800); step(); idle();
    chk("pop2", w_ras_top, 32'h308);
    jr_ra(32'h800); step(); idle();
    chk("pop3", w_ras_top, 32'h208);
    jr_ra(32'h800); step(); idle();
    chk("pop4_empty", {31'd0, w_ras_empty}, 32'd1);
    chk("pop4_top", w_ras_top, 32'h0);
    jr_ra(32'h800); step(); idle();
    chk("pop5_empty", {31'd0, w_ras_empty}, 32'd1);
    chk("pop5_top", w_ras_top, 32'h0);

    // simultaneous push/pop replaces top
    jal(32'h100); step(); idle();
    w_jump_op = 1; w_link_op = 1; w_ret_op = 1; w_br_pc_in = 32'h300; w_reg_pc = 32'h100;
    step(); idle();
    chk("repl_top", w_ras_top, 32'h308);
    jr_ra(32'h800); step(); idle();
    chk("repl_cnt", {31'd0, w_ras_empty}, 32'd1);

    // exception leaves RAS intact and beats a resolve
    jal(32'h100); step(); idle();
    w_exc_req = 1;
    step(); chk("exc_pc", w_pc_out, 32'h80);
    chk("exc_redir", {31'd0, w_redirect}, 32'd1);
    chk("exc_ras", w_ras_top, 32'h108);
    w_jump_op = 1; w_br_pc_in = 32'h500; w_reg_pc = 32'h300;
    step(); chk("exc_prio", w_pc_out, 32'h80);
    idle();

    // 6: exception in DS_WAIT
    w_rst_n = 0; #3; w_rst_n = 1;
    step(); step(); step();
    chk("e6_pre", w_pc_out, 32'hC);
    w_branch_op = 1; w_success = 1; w_br_pc_in = 32'h8; w_alu_imm = 32'h20;
    step(); idle();
    chk("e6_ds", w_pc_out, 32'h10);
    w_exc_req = 1;
    step(); chk("e6_exc", w_pc_out, 32'h80);
    w_exc_req = 0;
    step(); chk("e6_seq", w_pc_out, 32'h84);
    chk("e6_redir", {31'd0, w_redirect}, 32'd0);

    // async reset mid DS_WAIT
    w_branch_op = 1; w_success = 1; w_br_pc_in = 32'h80; w_alu_imm = 32'h20;
    step(); idle();
    chk("ar_ds", w_pc_out, 32'h88);
    #2; w_rst_n = 0; #1;
    chk("ar_pc", w_pc_out, 32'h0);
    chk("ar_redir", {31'd0, w_redirect}, 32'd0);
    w_rst_n = 1;
    step(); chk("ar_run", w_pc_out, 32'h4);
    chk("ar_run_redir", {31'd0, w_redirect}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
